// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the bit-serial word path: the feeder FSM state type,
// default word width / clear-pulse length (also used by the future output
// deserializer) and a counter-width helper.
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CLEAR = 2'd2
    } feeder_state_t;

    localparam int DEFAULT_WIDTH        = 16;
    localparam int DEFAULT_CLEAR_CYCLES = 1;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_hold_reg.sv
// -----------------------------------------------------------------------------
// serial_hold_reg
// One-word skid buffer for serial_word_feeder: a data register plus a full
// flag. load captures din and sets full; unload clears full (dout stays valid
// during the unload cycle so the consumer can take it on the same edge).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         capture din (only issued while empty)
//   unload       release the held word (only issued while full)
//   din / dout   word in / held word out
//   full         a word is held
// -----------------------------------------------------------------------------
module serial_hold_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    // load and unload are mutually exclusive by construction (load needs an
    // empty buffer, unload a full one), so their order here does not matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_feeder.sv
// -----------------------------------------------------------------------------
// serial_word_feeder
// Accepts a parallel word over valid/ready and shifts it out LSB-first on x,
// one bit per clock, then pulses frame_reset for CLEAR_CYCLES clocks to clear
// the downstream bit-serial 2's complementer.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset; aborts any word in flight
//   in_data      parallel word, captured on accept (in_valid & in_ready)
//   in_valid     word available
//   in_ready     block can take a word this cycle
//   x            serial bit, LSB first; 0 outside SHIFT
//   frame_reset  word-boundary clear, high only in CLEAR
//   busy         high in SHIFT or CLEAR
// Configuration:
//   SERIAL_FEEDER_SKID_EN  adds a one-word hold buffer so words arrive
//                          back-to-back with no idle cycle between frames.
// -----------------------------------------------------------------------------
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             frame_reset,
    output logic             busy
);

    localparam int CW  = cnt_width(WIDTH);
    localparam int CCW = cnt_width(CLEAR_CYCLES);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CCW-1:0] LAST_CLR = CCW'(CLEAR_CYCLES - 1);

    feeder_state_t    state, state_nxt;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    bit_cnt;
    logic [CCW-1:0]   clr_cnt;

    logic             accept;
    logic             last_bit;
    logic             last_clr;
    logic             start_shift;  // load shift_q and enter SHIFT on this edge
    logic [WIDTH-1:0] start_data;

    assign accept   = in_valid & in_ready;
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign last_clr = (state == CLEAR) && (clr_cnt == LAST_CLR);

`ifdef SERIAL_FEEDER_SKID_EN
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             load_direct;
    logic             hold_load;
    logic             hold_unload;

    assign in_ready = !hold_full;

    // A word arriving in IDLE, or in the last CLEAR cycle with nothing held,
    // goes straight into the shift register; any other accept is parked.
    // Sending the last-CLEAR arrival straight through keeps the buffer empty
    // whenever the FSM sits in IDLE.
    assign load_direct = accept & ((state == IDLE) | (last_clr & !hold_full));
    assign hold_load   = accept & !load_direct;
    assign hold_unload = last_clr & hold_full;

    assign start_shift = load_direct | hold_unload;
    assign start_data  = hold_unload ? hold_data : in_data;

    serial_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (hold_load),
        .unload (hold_unload),
        .din    (in_data),
        .dout   (hold_data),
        .full   (hold_full)
    );
`else
    assign in_ready    = (state == IDLE);
    assign start_shift = accept;
    assign start_data  = in_data;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a value held and infer a latch.
    always_comb begin
        state_nxt   = state;
        x           = 1'b0;
        frame_reset = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (start_shift) state_nxt = SHIFT;
            end
            SHIFT: begin
                x    = shift_q[0];
                busy = 1'b1;
                if (last_bit) state_nxt = CLEAR;
            end
            CLEAR: begin
                frame_reset = 1'b1;
                busy        = 1'b1;
                if (last_clr) state_nxt = start_shift ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register and counters. start_shift only occurs outside SHIFT, so
    // it never competes with the shift itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
            clr_cnt <= '0;
        end else begin
            if (start_shift) begin
                shift_q <= start_data;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                shift_q <= shift_q >> 1;
                bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
            end

            if ((state == CLEAR) && !last_clr) begin
                clr_cnt <= clr_cnt + CCW'(1);
            end else begin
                clr_cnt <= '0;
            end
        end
    end

endmodule
